// File: rtl/pb_pkg.sv
// Push-button debouncer shared constants and width helper.
// Defaults assume a 50 MHz clk (10 ms debounce, 0.5 s / 0.1 s repeat).
package pb_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_REPEAT_DELAY    = 25000000;
  localparam int DEFAULT_REPEAT_PERIOD   = 5000000;

  // Counter width holding 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pb_debounce_chan.sv
// One push-button channel: 2-flop sync, polarity fix, debounce, pulses.
// Auto-repeat press pulses exist only when PB_AUTOREPEAT_EN is defined.
module pb_debounce_chan
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key_raw,
  output logic key_db,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
  end

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          pressed;
  logic          mismatch;
  logic          accept;
  logic          db_d;
  logic          press_d;
  logic          rel_d;
  logic          rep_fire;

  assign pressed  = sync_q2 ^ IDLE_LVL;
  assign mismatch = (pressed != key_db);
  assign accept   = mismatch && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d   = '0;
    db_d    = key_db;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (accept) begin
      db_d    = pressed;
      press_d = pressed;
      rel_d   = ~pressed;
    end else if (mismatch) begin
      cnt_d = cnt_q + CW'(1);
    end
    press_d = press_d | rep_fire;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1       <= IDLE_LVL;
      sync_q2       <= IDLE_LVL;
      cnt_q         <= '0;
      key_db        <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_q1       <= key_raw;
      sync_q2       <= sync_q1;
      cnt_q         <= cnt_d;
      key_db        <= db_d;
      press_pulse   <= press_d;
      release_pulse <= rel_d;
    end
  end

`ifdef PB_AUTOREPEAT_EN
  localparam int REP_MAX =
    (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_w(REP_MAX);
  localparam logic [RW-1:0] REP_FIRST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] REP_NEXT  = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rep_cnt_q;
  logic [RW-1:0] rep_cnt_d;
  logic          rep_phase_q;
  logic          rep_phase_d;
  logic [RW-1:0] rep_target;

  assign rep_target = rep_phase_q ? REP_NEXT : REP_FIRST;

  // An accept while key_db is high is a release; it wins over a repeat.
  always_comb begin
    rep_fire    = 1'b0;
    rep_cnt_d   = '0;
    rep_phase_d = 1'b0;
    if (key_db && !accept) begin
      rep_phase_d = rep_phase_q;
      if (rep_cnt_q == rep_target) begin
        rep_fire    = 1'b1;
        rep_phase_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

endmodule

// File: rtl/pushbutton_debouncer.sv
// Debounced, active-high push-button bank feeding the PIO in_port.
// Define PB_AUTOREPEAT_EN for held-key auto-repeat press pulses.
module pushbutton_debouncer
  import pb_pkg::*;
#(
  parameter int NUM_BUTTONS     = 3,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] key_raw,
  output logic [NUM_BUTTONS-1:0] key_db,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    pb_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clk           (clk),
      .reset_n       (reset_n),
      .key_raw       (key_raw[i]),
      .key_db        (key_db[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_pushbutton_debouncer.sv
// Directed bench for pushbutton_debouncer (DEBOUNCE_CYCLES=8).
// Auto-repeat expectations follow PB_AUTOREPEAT_EN when defined.
module tb_pushbutton_debouncer;

  localparam int NB = 3;
  localparam int DC = 8;
  localparam int RD = 20;
  localparam int RP = 6;
  localparam int LAT = 2 + DC;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NB-1:0] key_raw;
  logic [NB-1:0] key_db;
  logic [NB-1:0] press_pulse;
  logic [NB-1:0] release_pulse;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pushbutton_debouncer #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (DC),
    .ACTIVE_LOW      (1),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .key_raw       (key_raw),
    .key_db        (key_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Edges until key_db[idx] changes; -1 if it never does within 40.
  task automatic wait_change(input int idx, output int n);
    logic prev;
    bit   done;
    prev = key_db[idx];
    n = -1;
    done = 0;
    for (int i = 1; i <= 40 && !done; i++) begin
      tick(1);
      if (key_db[idx] !== prev) begin
        n = i;
        done = 1;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    int bad;
    key_raw = 3'b111;
    reset_n = 1'b0;
    tick(3);
    checks++;
    if ({key_db, press_pulse, release_pulse} !== 9'b0) begin
      failures++;
      $display("FAIL reset_state got=%b want=0",
               {key_db, press_pulse, release_pulse});
    end
    reset_n = 1'b1;
    bad = 0;
    repeat (50) begin
      tick(1);
      if ({key_db, press_pulse, release_pulse} !== 9'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL reset_idle got=%0d nonzero cycles want=0", bad);
    end
    reset_n = 1'b0;
    key_raw = 3'b110;
    tick(2);
    reset_n = 1'b1;
    wait_change(0, n);
    checks++;
    if (n != LAT) begin
      failures++;
      $display("FAIL reset_held_latency got=%0d want=%0d", n, LAT);
    end
    checks++;
    if (press_pulse !== 3'b001 || release_pulse !== 3'b000) begin
      failures++;
      $display("FAIL reset_held_pulse got=%b/%b want=001/000",
               press_pulse, release_pulse);
    end
    tick(1);
    checks++;
    if (press_pulse !== 3'b000 || key_db !== 3'b001) begin
      failures++;
      $display("FAIL reset_held_after got=%b/%b want=000/001",
               press_pulse, key_db);
    end
    key_raw = 3'b111;
    wait_change(0, n);
    checks++;
    if (n != LAT || release_pulse !== 3'b001 || key_db !== 3'b000) begin
      failures++;
      $display("FAIL reset_held_release got=%0d/%b/%b want=%0d/001/000",
               n, release_pulse, key_db, LAT);
    end
    tick(1);
  endtask

  task automatic test_press_release();
    int n;
    key_raw[1] = 1'b0;
    wait_change(1, n);
    checks++;
    if (n != LAT || press_pulse !== 3'b010 || release_pulse !== 3'b000) begin
      failures++;
      $display("FAIL press got=%0d/%b/%b want=%0d/010/000",
               n, press_pulse, release_pulse, LAT);
    end
    tick(1);
    checks++;
    if (press_pulse !== 3'b000 || key_db !== 3'b010) begin
      failures++;
      $display("FAIL press_one_cycle got=%b/%b want=000/010",
               press_pulse, key_db);
    end
    key_raw[1] = 1'b1;
    wait_change(1, n);
    checks++;
    if (n != LAT || release_pulse !== 3'b010 || press_pulse !== 3'b000) begin
      failures++;
      $display("FAIL release got=%0d/%b/%b want=%0d/010/000",
               n, release_pulse, press_pulse, LAT);
    end
    tick(1);
    checks++;
    if (release_pulse !== 3'b000 || key_db !== 3'b000) begin
      failures++;
      $display("FAIL release_one_cycle got=%b/%b want=000/000",
               release_pulse, key_db);
    end
  endtask

  task automatic test_bounce();
    int n;
    int bad;
    bad = 0;
    for (int r = 0; r < 5; r++) begin
      key_raw[2] = 1'b0;
      repeat (5) begin
        tick(1);
        if (key_db[2] || press_pulse[2] || release_pulse[2]) bad++;
      end
      key_raw[2] = 1'b1;
      tick(1);
      if (key_db[2] || press_pulse[2] || release_pulse[2]) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bounce_reject got=%0d bad cycles want=0", bad);
    end
    key_raw[2] = 1'b0;
    wait_change(2, n);
    checks++;
    if (n != LAT || press_pulse !== 3'b100) begin
      failures++;
      $display("FAIL bounce_settle got=%0d/%b want=%0d/100",
               n, press_pulse, LAT);
    end
    key_raw[2] = 1'b1;
    wait_change(2, n);
    checks++;
    if (n != LAT || release_pulse !== 3'b100) begin
      failures++;
      $display("FAIL bounce_release got=%0d/%b want=%0d/100",
               n, release_pulse, LAT);
    end
    tick(1);
  endtask

  task automatic test_simultaneous();
    int n;
    key_raw = 3'b010;
    wait_change(0, n);
    checks++;
    if (n != LAT || key_db !== 3'b101 || press_pulse !== 3'b101) begin
      failures++;
      $display("FAIL simul_press got=%0d/%b/%b want=%0d/101/101",
               n, key_db, press_pulse, LAT);
    end
    tick(1);
    checks++;
    if (press_pulse !== 3'b000) begin
      failures++;
      $display("FAIL simul_press_clear got=%b want=000", press_pulse);
    end
    key_raw = 3'b111;
    wait_change(0, n);
    checks++;
    if (n != LAT || key_db !== 3'b000 || release_pulse !== 3'b101) begin
      failures++;
      $display("FAIL simul_release got=%0d/%b/%b want=%0d/000/101",
               n, key_db, release_pulse, LAT);
    end
    tick(1);
  endtask

  task automatic test_reset_mid_count();
    int n;
    key_raw[0] = 1'b0;
    tick(7);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({key_db, press_pulse, release_pulse} !== 9'b0) begin
      failures++;
      $display("FAIL midreset_assert got=%b want=0",
               {key_db, press_pulse, release_pulse});
    end
    tick(2);
    checks++;
    if ({key_db, press_pulse, release_pulse} !== 9'b0) begin
      failures++;
      $display("FAIL midreset_hold got=%b want=0",
               {key_db, press_pulse, release_pulse});
    end
    reset_n = 1'b1;
    wait_change(0, n);
    checks++;
    if (n != LAT || press_pulse !== 3'b001) begin
      failures++;
      $display("FAIL midreset_requalify got=%0d/%b want=%0d/001",
               n, press_pulse, LAT);
    end
    key_raw = 3'b111;
    wait_change(0, n);
    checks++;
    if (n != LAT || release_pulse !== 3'b001) begin
      failures++;
      $display("FAIL midreset_release got=%0d/%b want=%0d/001",
               n, release_pulse, LAT);
    end
    tick(1);
  endtask

  // Raw release at k=64 lands the debounced release at k=74, the same
  // cycle a repeat would otherwise be due.
  task automatic test_autorepeat();
    int   n;
    int   presses;
    int   want_presses;
    logic exp_db;
    logic exp_pr;
    logic exp_rl;
    key_raw[1] = 1'b0;
    wait_change(1, n);
    checks++;
    if (n != LAT || press_pulse !== 3'b010) begin
      failures++;
      $display("FAIL rep_first got=%0d/%b want=%0d/010",
               n, press_pulse, LAT);
    end
    presses = 1;
    for (int k = 1; k <= 90; k++) begin
      tick(1);
      exp_db = (k < 74);
      exp_rl = (k == 74);
`ifdef PB_AUTOREPEAT_EN
      exp_pr = (k >= RD) && (k < 74) && (((k - RD) % RP) == 0);
`else
      exp_pr = 1'b0;
`endif
      if (press_pulse[1]) presses++;
      checks++;
      if ({key_db[1], press_pulse[1], release_pulse[1]} !==
          {exp_db, exp_pr, exp_rl}) begin
        failures++;
        $display("FAIL rep_k%0d got db/pr/rl=%b%b%b want=%b%b%b", k,
                 key_db[1], press_pulse[1], release_pulse[1],
                 exp_db, exp_pr, exp_rl);
      end
      if (k == 64) key_raw[1] = 1'b1;
    end
`ifdef PB_AUTOREPEAT_EN
    want_presses = 10;
`else
    want_presses = 1;
`endif
    checks++;
    if (presses != want_presses) begin
      failures++;
      $display("FAIL rep_count got=%0d want=%0d", presses, want_presses);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    key_raw = 3'b111;
    test_reset();
    test_press_release();
    test_bounce();
    test_simultaneous();
    test_reset_mid_count();
    test_autorepeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
